// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: minutes:seconds BCD stopwatch counting rising edges of a
// divider tick that is synchronous to the system clock.
//   clockIn     - system clock, all state on rising edge
//   resetN      - asynchronous active-low reset
//   tickIn      - divider output; each 0->1 transition is a count event
//   startStopIn - raw start/stop button (async, active-high)
//   clearIn     - raw clear button (async, active-high)
//   lapIn       - raw lap button, only when BCD_STOPWATCH_LAP_EN is defined
//   digits      - {minTens, minOnes, secTens, secOnes} BCD
//   running     - high while in RUN
//   wrapPulse   - one-cycle pulse on the 59:59 -> 00:00 wrap
// Optional feature macro: BCD_STOPWATCH_LAP_EN (lap hold of the display).
module bcd_stopwatch #(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic        clockIn,
    input  logic        resetN,
    input  logic        tickIn,
    input  logic        startStopIn,
    input  logic        clearIn,
`ifdef BCD_STOPWATCH_LAP_EN
    input  logic        lapIn,
`endif
    output logic [15:0] digits,
    output logic        running,
    output logic        wrapPulse
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
`ifdef BCD_STOPWATCH_LAP_EN
    localparam int unsigned NB = 3;
`else
    localparam int unsigned NB = 2;
`endif
    localparam int unsigned B_SS  = 0;
    localparam int unsigned B_CLR = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    logic [NB-1:0] btn_raw_c;
    logic [NB-1:0] sync1_q, sync2_q, sync3_q;
    logic [NB-1:0] press_c;
    logic          tick_prev_q;
    logic          tick_rise_c;

    state_e        state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          wrap_q, wrap_d;

`ifdef BCD_STOPWATCH_LAP_EN
    localparam int unsigned B_LAP = 2;
    logic          hold_q, hold_d;
    logic [15:0]   lap_q, lap_d;
    logic [15:0]   disp_q, disp_d;
    assign btn_raw_c = {lapIn, clearIn, startStopIn};
`else
    assign btn_raw_c = {clearIn, startStopIn};
`endif

    // One press per assertion: rising edge of the synchronised button.
    assign press_c     = sync2_q & ~sync3_q;
    assign tick_rise_c = tickIn & ~tick_prev_q;

    // Input synchronisers and tick edge register.
    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            tick_prev_q <= 1'b0;
        end else begin
            sync1_q     <= btn_raw_c;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            tick_prev_q <= tickIn;
        end
    end

    // State, count and output registers.
    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
`ifdef BCD_STOPWATCH_LAP_EN
            hold_q    <= 1'b0;
            lap_q     <= '0;
            disp_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
`ifdef BCD_STOPWATCH_LAP_EN
            hold_q    <= hold_d;
            lap_q     <= lap_d;
            disp_q    <= disp_d;
`endif
        end
    end

    // Next-state: clear wins; the tick is judged against the current state,
    // so RUN+tick+startStop counts and PAUSE+tick+startStop does not.
    always_comb begin
        logic [3:0] so, st, mo, mt;
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;
        mt = count_q[15:12];
        mo = count_q[11:8];
        st = count_q[7:4];
        so = count_q[3:0];

        if (press_c[B_CLR]) begin
            state_d = S_IDLE;
            count_d = '0;
            presc_d = '0;
        end else begin
            if (state_q == S_RUN && tick_rise_c) begin
                if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
                    presc_d = '0;
                    // BCD ripple: each digit wraps at its limit and carries.
                    if (so != 4'd9) begin
                        so = so + 4'd1;
                    end else begin
                        so = 4'd0;
                        if (st != 4'd5) begin
                            st = st + 4'd1;
                        end else begin
                            st = 4'd0;
                            if (mo != 4'd9) begin
                                mo = mo + 4'd1;
                            end else begin
                                mo = 4'd0;
                                if (mt != 4'd5) begin
                                    mt = mt + 4'd1;
                                end else begin
                                    mt     = 4'd0;
                                    wrap_d = 1'b1;
                                end
                            end
                        end
                    end
                    count_d = {mt, mo, st, so};
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            if (press_c[B_SS]) begin
                case (state_q)
                    S_IDLE:  state_d = S_RUN;
                    S_RUN:   state_d = S_PAUSE;
                    S_PAUSE: state_d = S_RUN;
                    default: state_d = S_IDLE;
                endcase
            end
        end
        running_d = (state_d == S_RUN);
    end

`ifdef BCD_STOPWATCH_LAP_EN
    // Lap hold: toggled in RUN/PAUSE, snapshot of the count at the press edge.
    always_comb begin
        hold_d = hold_q;
        lap_d  = lap_q;
        if (press_c[B_CLR]) begin
            hold_d = 1'b0;
        end else if (press_c[B_LAP] && state_q != S_IDLE) begin
            hold_d = ~hold_q;
            lap_d  = count_q;
        end
        disp_d = hold_d ? lap_d : count_d;
    end

    assign digits = disp_q;
`else
    assign digits = count_q;
`endif

    assign running   = running_q;
    assign wrapPulse = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed self-checking bench for bcd_stopwatch. Two instances share all
// inputs: dut runs with one tick per second, dut3 with three.
module tb_bcd_stopwatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        ss = 1'b0;
    logic        clr = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] dig, dig3;
    logic        run, run3;
    logic        wrap, wrap3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_stopwatch #(.TICKS_PER_SEC(1)) dut (
        .clockIn(clk), .resetN(rst_n), .tickIn(tick),
        .startStopIn(ss), .clearIn(clr),
`ifdef BCD_STOPWATCH_LAP_EN
        .lapIn(lap),
`endif
        .digits(dig), .running(run), .wrapPulse(wrap)
    );

    bcd_stopwatch #(.TICKS_PER_SEC(3)) dut3 (
        .clockIn(clk), .resetN(rst_n), .tickIn(tick),
        .startStopIn(ss), .clearIn(clr),
`ifdef BCD_STOPWATCH_LAP_EN
        .lapIn(lap),
`endif
        .digits(dig3), .running(run3), .wrapPulse(wrap3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One tick rise, counted at the second edge; tick low again afterwards.
    task automatic tick_rise();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_rise();
    endtask

    // which: 0 startStop, 1 clear, 2 lap. Returns after the synchroniser settles.
    task automatic press(input int which);
        @(posedge clk); #1;
        case (which)
            0: ss = 1'b1;
            1: clr = 1'b1;
            default: lap = 1'b1;
        endcase
        repeat (2) @(posedge clk);
        #1 ss = 1'b0; clr = 1'b0; lap = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with tick toggling, then IDLE stays at zero.
        repeat (3) begin @(posedge clk); #1 tick = ~tick; end
        @(negedge clk);
        check("reset_digits", 32'(dig), 32'h0000);
        check("reset_running", 32'(run), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1 tick = ~tick; end
        tick = 1'b0;
        @(negedge clk);
        check("idle_digits", 32'(dig), 32'h0000);
        check("idle_running", 32'(run), 32'h0);

        // Start held for 100 cycles: running after edge 3, single press only.
        @(posedge clk); #1 ss = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("start_lat_edge2", 32'(run), 32'h0);
        @(posedge clk); @(negedge clk);
        check("start_lat_edge3", 32'(run), 32'h1);
        repeat (97) @(posedge clk);
        #1 ss = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("start_held_once", 32'(run), 32'h1);
        ticks(3);
        @(negedge clk);
        check("count_3", 32'(dig), 32'h0003);

        // Carry 09:59 -> 10:00, then 59:58 -> 59:59 -> wrap.
        press(1);
        check("clear_digits", 32'(dig), 32'h0000);
        check("clear_running", 32'(run), 32'h0);
        press(0);
        ticks(599);
        @(negedge clk);
        check("count_0959", 32'(dig), 32'h0959);
        tick_rise();
        @(negedge clk);
        check("count_1000", 32'(dig), 32'h1000);
        ticks(3598 - 600);
        @(negedge clk);
        check("count_5958", 32'(dig), 32'h5958);
        check("no_wrap_5958", 32'(wrap), 32'h0);
        tick_rise();
        @(negedge clk);
        check("count_5959", 32'(dig), 32'h5959);
        tick_rise();
        @(negedge clk);
        check("wrap_digits", 32'(dig), 32'h0000);
        check("wrap_pulse", 32'(wrap), 32'h1);
        @(negedge clk);
        check("wrap_one_cycle", 32'(wrap), 32'h0);

        // Prescaler of 3: 7 rises -> 2 seconds; clear zeroes the prescaler.
        press(1);
        press(0);
        ticks(7);
        @(negedge clk);
        check("tps1_7", 32'(dig), 32'h0007);
        check("tps3_7", 32'(dig3), 32'h0002);
        press(1);
        check("tps3_clear", 32'(dig3), 32'h0000);
        check("tps3_clear_run", 32'(run3), 32'h0);
        press(0);
        ticks(2);
        @(negedge clk);
        check("tps3_presc_zeroed", 32'(dig3), 32'h0000);
        tick_rise();
        @(negedge clk);
        check("tps3_third_rise", 32'(dig3), 32'h0001);
        check("tps1_3", 32'(dig), 32'h0003);

        // Clear coincident with a tick rise.
        @(posedge clk); #1 clr = 1'b1;
        repeat (2) @(posedge clk);
        #1 tick = 1'b1; clr = 1'b0;
        @(posedge clk); #1 tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("clear_vs_tick", 32'(dig), 32'h0000);
        check("clear_vs_tick_run", 32'(run), 32'h0);

        // Pause holds the count; startStop + tick in RUN counts then pauses.
        press(0);
        ticks(5);
        press(0);
        check("pause_running", 32'(run), 32'h0);
        ticks(10);
        @(negedge clk);
        check("pause_hold", 32'(dig), 32'h0005);
        press(0);
        check("resume_running", 32'(run), 32'h1);
        @(posedge clk); #1 ss = 1'b1;
        repeat (2) @(posedge clk);
        #1 tick = 1'b1; ss = 1'b0;
        @(posedge clk); #1 tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ss_tick_run_count", 32'(dig), 32'h0006);
        check("ss_tick_run_pause", 32'(run), 32'h0);

        // startStop + tick in PAUSE: tick ignored, back to RUN.
        @(posedge clk); #1 ss = 1'b1;
        repeat (2) @(posedge clk);
        #1 tick = 1'b1; ss = 1'b0;
        @(posedge clk); #1 tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ss_tick_pause_count", 32'(dig), 32'h0006);
        check("ss_tick_pause_run", 32'(run), 32'h1);
        ticks(2);
        @(negedge clk);
        check("resumed_count", 32'(dig), 32'h0008);

        // Asynchronous reset mid-run.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_digits", 32'(dig), 32'h0000);
        check("async_rst_running", 32'(run), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        ticks(2);
        @(negedge clk);
        check("post_rst_idle", 32'(dig), 32'h0000);

`ifdef BCD_STOPWATCH_LAP_EN
        // Lap ignored in IDLE, then freeze/unfreeze in RUN.
        press(2);
        press(0);
        tick_rise();
        @(negedge clk);
        check("lap_idle_ignored", 32'(dig), 32'h0001);
        ticks(3);
        press(2);
        ticks(3);
        @(negedge clk);
        check("lap_frozen", 32'(dig), 32'h0004);
        press(2);
        check("lap_released", 32'(dig), 32'h0007);
        press(2);
        press(1);
        check("lap_clear_drops", 32'(dig), 32'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
